// File: rtl/nv_nvdla_sync_rcv_pkg.sv
// Shared types for the toggle-handshake receiver.
// FSM encoding and settle counter width.
package nv_nvdla_sync_rcv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_PUSH   = 2'd2
    } rcv_state_e;

    localparam int SCW = 4;

endpackage

// File: rtl/nv_nvdla_sync_rcv_fifo.sv
// Small payload FIFO with valid/ready head.
// Accepts a push and a pop in the same cycle even when full.
module nv_nvdla_sync_rcv_fifo #(
    parameter  int DW    = 32,
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_pd,
    output logic          rd_pvld,
    input  logic          rd_prdy,
    output logic [DW-1:0] rd_pd,
    output logic [CW-1:0] cnt
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic          rd_en;

    function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign rd_pvld = (cnt_q != '0);
    assign rd_en   = rd_pvld && rd_prdy;
    assign rd_pd   = mem_q[rd_ptr_q];
    assign cnt     = cnt_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= wr_pd;
                wr_ptr_q        <= ptr_nxt(wr_ptr_q);
            end
            if (rd_en) begin
                rd_ptr_q <= ptr_nxt(rd_ptr_q);
            end
            unique case ({wr_en, rd_en})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/nv_nvdla_sync_req_rcv.sv
// Destination side of the 2-phase req/ack toggle crossing.
// Withholding ack is the only backpressure to the source.
module nv_nvdla_sync_req_rcv
    import nv_nvdla_sync_rcv_pkg::*;
#(
    parameter  int DW     = 32,
    parameter  int DEPTH  = 2,
    parameter  int SETTLE = 1,
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rstn,
    input  logic          req_sync,
    input  logic [DW-1:0] req_pd,
    output logic          ack_tgl,
    output logic          dat_pvld,
    input  logic          dat_prdy,
    output logic [DW-1:0] dat_pd,
    output logic [CW-1:0] fifo_cnt,
    output logic          proto_err
);

    localparam logic HAS_SETTLE = (SETTLE > 0);
    localparam logic [SCW-1:0] SETTLE_LD = HAS_SETTLE ? SCW'(SETTLE - 1) : '0;

    rcv_state_e     state_q, state_d;
    logic [SCW-1:0] settle_q, settle_d;
    logic           req_d_q;
    logic           ack_q, ack_d;
    logic           err_q, err_d;
    logic           pend_q, pend_d;
    logic           tgl_edge;
    logic           space;
    logic           wr_en;

    assign tgl_edge = req_sync ^ req_d_q;
    assign space    = (fifo_cnt < CW'(DEPTH)) || (dat_pvld && dat_prdy);

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        ack_d    = ack_q;
        err_d    = err_q;
        pend_d   = 1'b0;
        wr_en    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (tgl_edge && pend_q) begin
                    err_d = 1'b1;
                end
                if (tgl_edge || pend_q) begin
                    if (HAS_SETTLE) begin
                        settle_d = SETTLE_LD;
                        state_d  = ST_SETTLE;
                    end else begin
                        state_d  = ST_PUSH;
                    end
                end
            end
            ST_SETTLE: begin
                if (tgl_edge) begin
                    err_d = 1'b1;
                end
                if (settle_q == '0) begin
                    state_d = ST_PUSH;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            ST_PUSH: begin
                if (space) begin
                    wr_en   = 1'b1;
                    ack_d   = ~ack_q;
                    state_d = ST_IDLE;
                    // toggle arriving on the exit cycle is kept for IDLE
                    pend_d  = tgl_edge;
                end else if (tgl_edge) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            state_q  <= ST_IDLE;
            settle_q <= '0;
            req_d_q  <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            req_d_q  <= req_sync;
            ack_q    <= ack_d;
            err_q    <= err_d;
            pend_q   <= pend_d;
        end
    end

    assign ack_tgl   = ack_q;
    assign proto_err = err_q;

    nv_nvdla_sync_rcv_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (nvdla_core_clk),
        .rstn    (nvdla_core_rstn),
        .wr_en   (wr_en),
        .wr_pd   (req_pd),
        .rd_pvld (dat_pvld),
        .rd_prdy (dat_prdy),
        .rd_pd   (dat_pd),
        .cnt     (fifo_cnt)
    );

endmodule

// File: tb/tb_nv_nvdla_sync_req_rcv.sv
// Directed bench for the toggle-handshake receiver.
// Five builds cover the SETTLE/DEPTH variants.
module tb_nv_nvdla_sync_req_rcv;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // A: DEPTH=2 SETTLE=1
    logic req_a, ack_a, pvld_a, prdy_a, err_a;
    logic [31:0] pd_a, dpd_a;
    logic [1:0]  cnt_a;
    // B: SETTLE=0, C: SETTLE=15, D: SETTLE=3
    logic req_b, ack_b, pvld_b, err_b;
    logic [31:0] pd_b, dpd_b;
    logic [1:0]  cnt_b;
    logic req_c, ack_c, pvld_c, err_c;
    logic [31:0] pd_c, dpd_c;
    logic [1:0]  cnt_c;
    logic req_d, ack_d, pvld_d, err_d;
    logic [31:0] pd_d, dpd_d;
    logic [1:0]  cnt_d;
    // E: DEPTH=3 SETTLE=1
    logic req_e, ack_e, pvld_e, prdy_e, err_e;
    logic [31:0] pd_e, dpd_e;
    logic [1:0]  cnt_e;
    logic        tog_e;
    logic [31:0] popq[$];
    int          maxcnt;

    nv_nvdla_sync_req_rcv #(.DW(32), .DEPTH(2), .SETTLE(1)) u_a (
        .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
        .req_sync(req_a), .req_pd(pd_a), .ack_tgl(ack_a),
        .dat_pvld(pvld_a), .dat_prdy(prdy_a), .dat_pd(dpd_a),
        .fifo_cnt(cnt_a), .proto_err(err_a));

    nv_nvdla_sync_req_rcv #(.DW(32), .DEPTH(2), .SETTLE(0)) u_b (
        .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
        .req_sync(req_b), .req_pd(pd_b), .ack_tgl(ack_b),
        .dat_pvld(pvld_b), .dat_prdy(1'b0), .dat_pd(dpd_b),
        .fifo_cnt(cnt_b), .proto_err(err_b));

    nv_nvdla_sync_req_rcv #(.DW(32), .DEPTH(2), .SETTLE(15)) u_c (
        .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
        .req_sync(req_c), .req_pd(pd_c), .ack_tgl(ack_c),
        .dat_pvld(pvld_c), .dat_prdy(1'b0), .dat_pd(dpd_c),
        .fifo_cnt(cnt_c), .proto_err(err_c));

    nv_nvdla_sync_req_rcv #(.DW(32), .DEPTH(2), .SETTLE(3)) u_d (
        .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
        .req_sync(req_d), .req_pd(pd_d), .ack_tgl(ack_d),
        .dat_pvld(pvld_d), .dat_prdy(1'b0), .dat_pd(dpd_d),
        .fifo_cnt(cnt_d), .proto_err(err_d));

    nv_nvdla_sync_req_rcv #(.DW(32), .DEPTH(3), .SETTLE(1)) u_e (
        .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
        .req_sync(req_e), .req_pd(pd_e), .ack_tgl(ack_e),
        .dat_pvld(pvld_e), .dat_prdy(prdy_e), .dat_pd(dpd_e),
        .fifo_cnt(cnt_e), .proto_err(err_e));

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n cycles; inputs change and outputs are read 1ns after posedge.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            if (pvld_e && prdy_e) popq.push_back(dpd_e);
            @(posedge clk);
            #1;
            if (int'(cnt_e) > maxcnt) maxcnt = int'(cnt_e);
            if (tog_e) prdy_e = ~prdy_e;
        end
    endtask

    initial begin
        int w;
        rstn = 1'b0;
        req_a = 0; pd_a = 0; prdy_a = 0;
        req_b = 0; pd_b = 0;
        req_c = 0; pd_c = 0;
        req_d = 0; pd_d = 0;
        req_e = 0; pd_e = 0; prdy_e = 0; tog_e = 0;
        maxcnt = 0;
        tick(3);
        rstn = 1'b1;
        tick(1);

        chk("rst_ack", ack_a, 0);
        chk("rst_pvld", pvld_a, 0);
        chk("rst_pd", dpd_a, 0);
        chk("rst_cnt", cnt_a, 0);
        chk("rst_err", err_a, 0);

        // single transfer, SETTLE=1
        pd_a = 32'hDEADBEEF; req_a = 1;
        tick(2);
        chk("t1_ack_early", ack_a, 0);
        chk("t1_pvld_early", pvld_a, 0);
        tick(1);
        chk("t1_ack", ack_a, 1);
        chk("t1_pvld", pvld_a, 1);
        chk("t1_pd", dpd_a, 32'hDEADBEEF);
        chk("t1_cnt", cnt_a, 1);
        prdy_a = 1;
        tick(1);
        chk("t1_pop_pvld", pvld_a, 0);
        chk("t1_pop_cnt", cnt_a, 0);
        prdy_a = 0;

        // backpressure: 1, 2 queued, 3 held in PUSH
        pd_a = 1; req_a = 0;
        tick(3);
        chk("bp1_ack", ack_a, 0);
        chk("bp1_cnt", cnt_a, 1);
        pd_a = 2; req_a = 1;
        tick(3);
        chk("bp2_ack", ack_a, 1);
        chk("bp2_cnt", cnt_a, 2);
        pd_a = 3; req_a = 0;
        tick(5);
        chk("bp3_ack_held", ack_a, 1);
        chk("bp3_cnt", cnt_a, 2);
        chk("bp_head1", dpd_a, 1);
        prdy_a = 1;
        tick(1);
        chk("bp_swap_cnt", cnt_a, 2);
        chk("bp_swap_ack", ack_a, 0);
        chk("bp_head2", dpd_a, 2);
        tick(1);
        chk("bp_head3", dpd_a, 3);
        chk("bp_cnt1", cnt_a, 1);
        tick(1);
        chk("bp_empty", pvld_a, 0);
        prdy_a = 0;

        // SETTLE=0 and SETTLE=15 latency
        pd_b = 32'hB0; req_b = 1;
        pd_c = 32'hC15; req_c = 1;
        tick(1);
        chk("s0_ack_early", ack_b, 0);
        tick(1);
        chk("s0_ack", ack_b, 1);
        chk("s0_pd", dpd_b, 32'hB0);
        chk("s15_ack_mid", ack_c, 0);
        tick(14);
        chk("s15_ack_early", ack_c, 0);
        tick(1);
        chk("s15_ack", ack_c, 1);
        chk("s15_pd", dpd_c, 32'hC15);

        // protocol error, SETTLE=3
        pd_d = 32'h11; req_d = 1;
        tick(1);
        req_d = 0;
        tick(1);
        chk("pe_err", err_d, 1);
        tick(2);
        chk("pe_ack_early", ack_d, 0);
        tick(1);
        chk("pe_ack", ack_d, 1);
        chk("pe_cnt", cnt_d, 1);
        chk("pe_pd", dpd_d, 32'h11);
        tick(10);
        chk("pe_ack_once", ack_d, 1);
        chk("pe_cnt_once", cnt_d, 1);
        chk("pe_err_sticky", err_d, 1);

        // reset while in SETTLE with one entry queued
        pd_a = 32'hA5; req_a = 1;
        tick(3);
        chk("rm_cnt_pre", cnt_a, 1);
        chk("rm_ack_pre", ack_a, 1);
        pd_a = 32'h5A; req_a = 0;
        tick(1);
        rstn = 1'b0;
        tick(1);
        chk("rm_pvld", pvld_a, 0);
        chk("rm_cnt", cnt_a, 0);
        chk("rm_ack", ack_a, 0);
        chk("rm_err", err_a, 0);
        chk("rm_err_d", err_d, 0);
        rstn = 1'b1;
        pd_a = 32'h1234; req_a = 1;
        tick(3);
        chk("rm_new_ack", ack_a, 1);
        chk("rm_new_pvld", pvld_a, 1);
        chk("rm_new_pd", dpd_a, 32'h1234);

        // wrap: DEPTH=3, consumer ready toggling every cycle
        tog_e = 1;
        maxcnt = 0;
        for (int i = 0; i < 10; i++) begin
            req_e = ~req_e;
            pd_e = i;
            w = 0;
            while (ack_e !== req_e && w < 40) begin
                tick(1);
                w++;
            end
            chk("wrap_ack_seen", 32'(w < 40), 1);
        end
        w = 0;
        while ((cnt_e != 0 || popq.size() < 10) && w < 40) begin
            tick(1);
            w++;
        end
        tog_e = 0;
        chk("wrap_count", popq.size(), 10);
        for (int i = 0; i < 10; i++) begin
            chk("wrap_order", (i < popq.size()) ? popq[i] : 32'hFFFF_FFFF, i);
        end
        chk("wrap_maxcnt", 32'(maxcnt <= 3), 1);
        chk("wrap_err", err_e, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nv_nvdla_sync_req_rcv.md
Name: nv_nvdla_sync_req_rcv

Overview:
- Destination-side receiver of the 2-phase toggle req/ack handshake used to carry a multi-bit payload across clock domains.
- Consumes the request toggle after it has passed through the 3-flop strict synchronizer.
- Samples the quasi-static payload, buffers it in a small FIFO with a valid/ready output, and returns an ack toggle to the source through the return-path synchronizer.
- Withholding the ack is the only backpressure to the source domain.

Parameters:
- DW, 32, payload width in bits.
- DEPTH, 2, FIFO entries; must be >= 1.
- SETTLE, 1, extra destination cycles to wait after toggle detect before sampling req_pd; 0..15.

Ports:
- nvdla_core_clk  input  1  destination-domain clock; sole clock of the block.
- nvdla_core_rstn  input  1  reset, synchronous, active-low.
- req_sync  input  1  request toggle, already 3-flop synchronized into nvdla_core_clk.
- req_pd  input  DW  payload from the source domain, held stable from the req toggle until the ack is seen by the source.
- ack_tgl  output  1  ack toggle; feeds the return-path synchronizer to the source clock.
- dat_pvld  output  1  FIFO head valid.
- dat_prdy  input  1  consumer ready.
- dat_pd  output  DW  FIFO head payload.
- fifo_cnt  output  $clog2(DEPTH+1)  current occupancy.
- proto_err  output  1  sticky; a toggle arrived while a transfer was still in flight.

Behaviour:
- Clock and reset: one clock, nvdla_core_clk. Reset is synchronous and active-low on nvdla_core_rstn; every flop clears on a rising clock edge while rstn=0.
- Reset values: req_d=0, ack_tgl=0, dat_pvld=0, dat_pd=0, fifo_cnt=0, proto_err=0, state=IDLE, settle_cnt=0.
- Edge detect: edge = req_sync ^ req_d. req_d <= req_sync every cycle. Both toggle directions count.
- State machine:
  - IDLE: on edge, if SETTLE>0 load settle_cnt=SETTLE-1 and go to SETTLE; otherwise go to PUSH.
  - SETTLE: decrement settle_cnt; when settle_cnt==0 go to PUSH.
  - PUSH: when space, write req_pd into FIFO, flip ack_tgl, go to IDLE. Otherwise hold in PUSH with ack_tgl unchanged.
- space definition: fifo_cnt<DEPTH, or (fifo_cnt==DEPTH and dat_pvld and dat_prdy). Pop and push may occur in the same cycle while full.
- Latency, edge detected in cycle T, empty FIFO: push at T+1+SETTLE. ack_tgl and dat_pvld both change in cycle T+2+SETTLE (registered).
- Pop: when dat_pvld and dat_prdy. dat_pd is stable while dat_pvld=1 and dat_prdy=0.
- fifo_cnt: +1 on push only, -1 on pop only, unchanged on both. It never exceeds DEPTH and never underflows.
- FIFO pointers wrap modulo DEPTH; DEPTH need not be a power of two.
- Protocol error: an edge detected while state!=IDLE sets proto_err. That edge is dropped. proto_err clears only on reset.
- An edge in the same cycle the FSM returns to IDLE from PUSH is evaluated next cycle, not dropped, since req_d already tracks it.
- Reset mid-transfer: the in-flight payload is discarded and ack_tgl returns to 0. The source side must be reset in the same reset window, so the req and ack toggles restart from 0/0.

Decomposition:
- Package nv_nvdla_sync_rcv_pkg: FSM state typedef (IDLE, SETTLE, PUSH, 2-bit encoding) and the SETTLE counter width constant (4).
- One sub-module, nv_nvdla_sync_rcv_fifo:
  - Parameters DW and DEPTH.
  - Ports: wr_en, wr_pd, rd_pvld, rd_prdy, rd_pd, cnt.
  - Registered head, synchronous reset, same-cycle push/pop when full.
- The top module holds the edge detect, FSM, settle counter, ack and error logic.

Test Plan:
- Reset, then single transfer, SETTLE=1, DEPTH=2: toggle req_sync 0->1 with req_pd=0xDEADBEEF, detect at cycle T -> ack_tgl=1 and dat_pvld=1 with dat_pd=0xDEADBEEF at T+3; dat_prdy=1 pops it and fifo_cnt returns to 0.
- Backpressure, dat_prdy=0, DEPTH=2: three sequential handshakes with payloads 1, 2, 3 -> first two acked, fifo_cnt=2; third holds in PUSH with ack_tgl unflipped. Raise dat_prdy -> pop of 1 and push of 3 in the same cycle, fifo_cnt stays 2, ack flips; output order is 1, 2, 3.
- SETTLE=0 and SETTLE=15 builds: edge at T -> ack toggles at T+2 and T+17 respectively.
- Protocol error: second req_sync toggle one cycle after the first, SETTLE=3 -> proto_err=1 and stays 1; exactly one FIFO entry (first payload) and one ack flip.
- Reset mid-operation: assert nvdla_core_rstn=0 while in SETTLE with one entry queued -> next cycle dat_pvld=0, fifo_cnt=0, ack_tgl=0, proto_err=0, state=IDLE; a fresh 0->1 handshake then completes normally.
- Wrap: DEPTH=3, 10 back-to-back handshakes with dat_prdy toggling every cycle -> in-order payloads 0..9, no loss or duplication, fifo_cnt never exceeds 3.
